regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file with a per-register pending scoreboard, for dual-issue pipeline experiments.
- Supplies NR read ports and NW write ports, with same-cycle write-to-read bypass, an optional hard-wired zero register and full reset of every entry.
- Tracks which registers have an in-flight producer, so decode can stall without a separate scoreboard block.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; DEPTH = 2**AW entries.
- NR, 2, number of read ports (1..4).
- NW, 1, number of write ports (1..2).
- ZERO_REG, 1, 1 = entry 0 always reads 0, ignores writes and is never pending.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- raddr  in  NR*AW  read addresses; port i is bits [i*AW +: AW].
- rdata  out  NR*DW  read data, combinational.
- rbusy  out  NR  pending flag of the register addressed by each read port, combinational.
- wen  in  NW  write enables.
- waddr  in  NW*AW  write addresses.
- wdata  in  NW*DW  write data.
- wclr  in  NW  per-port flag: this write also clears the pending bit of waddr.
- rsv_en  in  1  reserve request: mark rsv_addr pending.
- rsv_addr  in  AW  register to reserve.
- flush  in  1  clear all pending bits; data is untouched.

Behaviour:
- Storage: DEPTH x DW array. Pending state: DEPTH-bit vector busy.
- Reset (rst=1 at posedge): all DEPTH entries are cleared to 0, including the top entry, and busy is cleared to 0. Outputs during reset are combinational from the array and bypass, exactly as when not in reset. Writes, reserves and flush presented in a reset cycle are discarded.
- Write (posedge, rst=0): for each port j with wen[j]=1, array[waddr_j] <= wdata_j.
  - Same address on two write ports: the higher port index wins.
  - With ZERO_REG=1, a write to address 0 is dropped.
- Read, combinational, zero latency:
  - With ZERO_REG=1 and raddr_i=0, rdata_i=0 regardless of bypass.
  - Otherwise, if any write port j has wen[j]=1 and waddr_j==raddr_i, rdata_i = wdata of the highest such j (bypass).
  - Otherwise, rdata_i = array[raddr_i].
- Pending update (posedge, rst=0), evaluated in this order:
  1. flush=1: busy <= 0 and the step-2 reservation is ignored. Clears from step 3 are irrelevant.
  2. Reserve: rsv_en=1 sets busy[rsv_addr]. With ZERO_REG=1, rsv_addr=0 is ignored.
  3. Clear: for each j with wen[j] & wclr[j], busy[waddr_j] is cleared, unless the same register is being reserved this cycle. Set beats clear, because the reservation is a newer producer.
  - A wclr with wen=0 has no effect.
- rbusy_i rules:
  - Nominally busy[raddr_i].
  - Forced 0 when a same-cycle write port with wen&wclr targets raddr_i. The consumer receives the bypassed data and need not stall.
  - Forced 0 for address 0 when ZERO_REG=1.
  - A same-cycle rsv_en does not raise rbusy; it takes effect next cycle.
  - Not affected by flush in the flush cycle; flush takes effect next cycle.
- Write latency: data is visible via bypass in the write cycle and via the array from the next cycle. Reserve latency: 1 cycle.
- Rewriting an unpending register with wclr=1 is legal and is a no-op on busy.
- Parameter range: outside NR 1..4 or NW 1..2 elaboration fails (assertion).

Test Plan:
- Reset fill: write 0xA5A5_0000+k to every k (ZERO_REG=0), pulse rst, read all 32 addresses -> every entry 0, including entry 31.
- Bypass and priority (NW=2): same cycle, wen=2'b11, both waddr=7, wdata0=0x1111, wdata1=0x2222, raddr0=7 -> rdata0=0x2222 that cycle and after; with ZERO_REG=1, a write of 0xFFFF to reg 0 -> reads 0.
- Scoreboard lifecycle:
  - rsv_en with rsv_addr=5 at cycle t -> rbusy for reg 5 is 0 at t and 1 at t+1.
  - Write to reg 5 with wclr=1 and 0xBEEF at t+3 -> rbusy 0 and rdata 0xBEEF at t+3; busy bit is 0 at t+4.
- Set-vs-clear collision: reg 9 pending; same cycle rsv_addr=9 and a wclr write to 9 -> rbusy 0 that cycle, 1 the next cycle, with data updated.
- Flush: reserve regs 3, 4, 5, then flush with rsv_en on reg 6 -> all rbusy 0 the next cycle, including reg 6; data unchanged.
- Reset mid-operation: rsv_en and wen asserted together with rst -> after reset, the target data reads 0 and its busy bit is 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write-to-read bypass and a
// per-register pending scoreboard, so decode can stall on in-flight producers.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR*AW-1:0]   raddr,
  output logic [NR*DW-1:0]   rdata,
  output logic [NR-1:0]      rbusy,
  input  logic [NW-1:0]      wen,
  input  logic [NW*AW-1:0]   waddr,
  input  logic [NW*DW-1:0]   wdata,
  input  logic [NW-1:0]      wclr,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  input  logic               flush
);

  localparam int DEPTH    = 2**AW;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  // Port counts outside the supported range stop elaboration.
  if (NR < 1 || NR > 4) begin : g_bad_nr
    $error("regfile_mp: NR must be in 1..4");
  end
  if (NW < 1 || NW > 2) begin : g_bad_nw
    $error("regfile_mp: NW must be in 1..2");
  end

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [NW-1:0]    wr_ok;
  logic             rsv_ok;

  // Qualify writes and reservations: the zero register never takes either.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NW; j++) begin
      wr_ok[j] = wen[j] & ~(HAS_ZERO && (waddr[j*AW +: AW] == '0));
    end
    rsv_ok = rsv_en & ~(HAS_ZERO && (rsv_addr == '0));
  end

  // Next array contents: reset wipes every entry; otherwise higher write ports override lower ones.
  always_comb begin
    mem_d = mem_q;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_d[k] = '0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wr_ok[j]) begin
          mem_d[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
        end
      end
    end
  end

  // Next pending vector: flush dominates; a reservation beats a same-register clear (newer producer).
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wen[j] && wclr[j]) begin
          busy_d[waddr[j*AW +: AW]] = 1'b0;
        end
      end
      if (rsv_ok) begin
        busy_d[rsv_addr] = 1'b1;
      end
    end
    if (HAS_ZERO) begin
      busy_d[0] = 1'b0;
    end
  end

  // Storage register update.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pending register update; reset also discards any reserve or flush in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Combinational read ports: zero register, then bypass from the highest matching write port, then array.
  always_comb begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          rb;
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rd    = '0;
    rb    = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ra = raddr[i*AW +: AW];
      rd = mem_q[ra];
      rb = busy_q[ra];
      for (int j = 0; j < NW; j++) begin
        if (wen[j] && (waddr[j*AW +: AW] == ra)) begin
          rd = wdata[j*DW +: DW];
          if (wclr[j]) begin
            rb = 1'b0;
          end
        end
      end
      if (HAS_ZERO && (ra == '0)) begin
        rd = '0;
        rb = 1'b0;
      end
      rdata[i*DW +: DW] = rd;
      rbusy[i]          = rb;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two instances (ZERO_REG=0 and ZERO_REG=1,
// NR=2, NW=2) share one stimulus stream; a reference model predicts every
// read port each cycle and a negedge monitor compares.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NR*AW-1:0] raddr;
  logic [NW-1:0]    wen;
  logic [NW-1:0]    wclr;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             flush;
  logic [NR*DW-1:0] rdata0, rdata1;
  logic [NR-1:0]    rbusy0, rbusy1;

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(0)) u_z0 (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata0), .rbusy(rbusy0),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wclr(wclr),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush));

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1)) u_z1 (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata1), .rbusy(rbusy1),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wclr(wclr),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush));

  // Reference state: index 0 models ZERO_REG=0, index 1 models ZERO_REG=1.
  logic [31:0] mm [2][32];
  bit          bb [2][32];

  typedef struct {
    logic [3:0][31:0] rd;
    logic [3:0]       rb;
    logic [1:0]       dmask;
    int               di;
    int               dp;
    logic [31:0]      dd;
    logic             db;
    int               tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag    = 0;

  function automatic int wa(int j);
    return int'(waddr[j*AW +: AW]);
  endfunction

  function automatic logic [31:0] wd(int j);
    return wdata[j*DW +: DW];
  endfunction

  function automatic int ra(int p);
    return int'(raddr[p*AW +: AW]);
  endfunction

  // What a read port should show right now, from the stored state plus this cycle's writes.
  function automatic void model_read(input int z, input int a,
                                     output logic [31:0] d, output logic b);
    d = mm[z][a];
    b = bb[z][a];
    for (int j = 0; j < NW; j++) begin
      if (wen[j] && wa(j) == a) begin
        d = wd(j);
        if (wclr[j]) b = 1'b0;
      end
    end
    if (z == 1 && a == 0) begin
      d = 32'h0;
      b = 1'b0;
    end
  endfunction

  // State change at a clock edge.
  task automatic model_clock();
    for (int z = 0; z < 2; z++) begin
      if (rst) begin
        for (int k = 0; k < 32; k++) begin
          mm[z][k] = 32'h0;
          bb[z][k] = 1'b0;
        end
      end else begin
        bit rsv_ok;
        for (int j = 0; j < NW; j++)
          if (wen[j] && !(z == 1 && wa(j) == 0)) mm[z][wa(j)] = wd(j);
        rsv_ok = rsv_en && !(z == 1 && rsv_addr == 5'd0);
        if (flush) begin
          for (int k = 0; k < 32; k++) bb[z][k] = 1'b0;
        end else begin
          for (int j = 0; j < NW; j++)
            if (wen[j] && wclr[j] && !(rsv_ok && wa(j) == int'(rsv_addr)))
              bb[z][wa(j)] = 1'b0;
          if (rsv_ok) bb[z][rsv_addr] = 1'b1;
        end
      end
    end
  endtask

  // One driven cycle: predict outputs, queue them, advance the model at the edge.
  task automatic cyc_chk(input logic [1:0] dm, input int di, input int dp,
                         input logic [31:0] dd, input logic db);
    exp_t e;
    logic [31:0] d;
    logic b;
    for (int z = 0; z < 2; z++) begin
      for (int p = 0; p < NR; p++) begin
        model_read(z, ra(p), d, b);
        e.rd[z*2+p] = d;
        e.rb[z*2+p] = b;
      end
    end
    e.dmask = dm; e.di = di; e.dp = dp; e.dd = dd; e.db = db; e.tag = tag;
    tag++;
    q.push_back(e);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic cyc();
    cyc_chk(2'b00, 0, 0, 32'h0, 1'b0);
  endtask

  task automatic idle();
    rst = 1'b0; wen = '0; wclr = '0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [31:0] get_rd(int z, int p);
    return (z == 0) ? rdata0[p*DW +: DW] : rdata1[p*DW +: DW];
  endfunction

  function automatic logic get_rb(int z, int p);
    return (z == 0) ? rbusy0[p] : rbusy1[p];
  endfunction

  // Monitor: compare every queued prediction against the DUT outputs mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (get_rd(k/2, k%2) !== e.rd[k]) begin
          errors++;
          $display("FAIL rdata step%0d inst%0d port%0d: got %h expected %h",
                   e.tag, k/2, k%2, get_rd(k/2, k%2), e.rd[k]);
        end
        checks++;
        if (get_rb(k/2, k%2) !== e.rb[k]) begin
          errors++;
          $display("FAIL rbusy step%0d inst%0d port%0d: got %b expected %b",
                   e.tag, k/2, k%2, get_rb(k/2, k%2), e.rb[k]);
        end
      end
      if (e.dmask[0]) begin
        checks++;
        if (get_rd(e.di, e.dp) !== e.dd) begin
          errors++;
          $display("FAIL directed_rdata step%0d inst%0d port%0d: got %h expected %h",
                   e.tag, e.di, e.dp, get_rd(e.di, e.dp), e.dd);
        end
      end
      if (e.dmask[1]) begin
        checks++;
        if (get_rb(e.di, e.dp) !== e.db) begin
          errors++;
          $display("FAIL directed_rbusy step%0d inst%0d port%0d: got %b expected %b",
                   e.tag, e.di, e.dp, get_rb(e.di, e.dp), e.db);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; rsv_addr = '0;
    @(posedge clk);
    model_clock();
    #1;
    // Reset state, outputs still live while rst is held
    cyc_chk(2'b11, 0, 0, 32'h0, 1'b0);
    cyc_chk(2'b11, 1, 1, 32'h0, 1'b0);
    idle();

    // Reset fill: write every entry, reset, read everything back as zero
    for (int k = 0; k < 32; k++) begin
      wen = 2'b01; waddr = {5'd0, 5'(k)}; wdata = {32'h0, 32'hA5A5_0000 + k};
      raddr = {5'(k), 5'(k)};
      cyc();
    end
    idle(); rst = 1'b1; cyc(); idle();
    for (int k = 0; k < 32; k++) begin
      raddr = {5'(31 - k), 5'(k)};
      cyc_chk(2'b11, 0, 0, 32'h0, 1'b0);
    end

    // Bypass with write-port priority
    wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h2222, 32'h1111}; raddr = {5'd0, 5'd7};
    cyc_chk(2'b11, 0, 0, 32'h2222, 1'b0);
    idle();
    cyc_chk(2'b01, 0, 0, 32'h2222, 1'b0);
    cyc_chk(2'b01, 1, 0, 32'h2222, 1'b0);

    // Zero register ignores writes and bypass
    wen = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFF}; raddr = {5'd0, 5'd0};
    cyc_chk(2'b11, 1, 0, 32'h0, 1'b0);
    idle();
    cyc_chk(2'b11, 1, 0, 32'h0, 1'b0);
    cyc_chk(2'b01, 0, 0, 32'hFFFF, 1'b0);

    // Scoreboard lifecycle on reg 5
    rsv_en = 1'b1; rsv_addr = 5'd5; raddr = {5'd0, 5'd5};
    cyc_chk(2'b10, 1, 0, 32'h0, 1'b0);
    idle();
    cyc_chk(2'b10, 1, 0, 32'h0, 1'b1);
    cyc_chk(2'b10, 1, 0, 32'h0, 1'b1);
    wen = 2'b01; wclr = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hBEEF};
    cyc_chk(2'b11, 1, 0, 32'hBEEF, 1'b0);
    idle();
    cyc_chk(2'b11, 1, 0, 32'hBEEF, 1'b0);

    // Set beats clear on reg 9
    rsv_en = 1'b1; rsv_addr = 5'd9; raddr = {5'd0, 5'd9};
    cyc();
    idle();
    cyc_chk(2'b10, 1, 0, 32'h0, 1'b1);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    wen = 2'b01; wclr = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h9999};
    cyc_chk(2'b11, 1, 0, 32'h9999, 1'b0);
    idle();
    cyc_chk(2'b11, 1, 0, 32'h9999, 1'b1);

    // Flush wins over a same-cycle reservation
    rsv_en = 1'b1; rsv_addr = 5'd3; cyc();
    rsv_addr = 5'd4; cyc();
    rsv_addr = 5'd5; cyc();
    flush = 1'b1; rsv_addr = 5'd6; raddr = {5'd4, 5'd3};
    cyc_chk(2'b10, 1, 0, 32'h0, 1'b1);
    idle();
    cyc_chk(2'b10, 1, 0, 32'h0, 1'b0);
    raddr = {5'd6, 5'd5};
    cyc_chk(2'b10, 1, 1, 32'h0, 1'b0);
    cyc_chk(2'b11, 1, 0, 32'hBEEF, 1'b0);

    // Reset in the middle of a write and reservation
    wen = 2'b01; waddr = {5'd0, 5'd10}; wdata = {32'h0, 32'h5555}; raddr = {5'd0, 5'd10};
    cyc();
    idle();
    cyc_chk(2'b01, 1, 0, 32'h5555, 1'b0);
    rst = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd10;
    wen = 2'b01; waddr = {5'd0, 5'd10}; wdata = {32'h0, 32'h1234};
    cyc_chk(2'b01, 1, 0, 32'h1234, 1'b0);
    idle();
    cyc_chk(2'b11, 1, 0, 32'h0, 1'b0);
    cyc_chk(2'b11, 0, 0, 32'h0, 1'b0);

    // Randomized traffic, addresses biased toward a small window for collisions
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wen      = 2'($urandom);
      wclr     = 2'($urandom);
      for (int j = 0; j < NW; j++) begin
        waddr[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        wdata[j*DW +: DW] = $urandom;
      end
      for (int p = 0; p < NR; p++)
        raddr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      cyc();
    end
    idle();

    for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", q.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
